// File: rtl/timer_entry_loader.sv
// Keypad entry register and sequencer for a three-digit (M:SS) countdown.
// Collects BCD digits while idle, validates the entry on start, issues a
// one-cycle parallel load to the external mod-10 counter chain, then
// enables counting until the chain reports zero or the user pauses/cancels.
module timer_entry_loader (
  input  logic       clk,
  input  logic       clear,
  input  logic       key_valid,
  input  logic [3:0] key_digit,
  input  logic       start,
  input  logic       stop,
  input  logic       timer_zero,
  output logic       loadn,
  output logic [3:0] data_ones,
  output logic [3:0] data_tens,
  output logic [3:0] data_mins,
  output logic       en,
  output logic       busy,
  output logic       done,
  output logic       err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_PAUSE,
    S_DONE
  } state_e;

  state_e     state_q, state_d;
  logic [3:0] ones_q, ones_d;
  logic [3:0] tens_q, tens_d;
  logic [3:0] mins_q, mins_d;
  // High only in the first RUN cycle after LOAD, so a stale timer_zero
  // from before the load has no effect while the counter settles.
  logic       first_q, first_d;
  logic       err_q, err_d;

  // State, digit and pulse registers; clear aborts everything at once.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state_q <= S_IDLE;
      ones_q  <= '0;
      tens_q  <= '0;
      mins_q  <= '0;
      first_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ones_q  <= ones_d;
      tens_q  <= tens_d;
      mins_q  <= mins_d;
      first_q <= first_d;
      err_q   <= err_d;
    end
  end

  // Next-state and digit-register update.
  // In IDLE the command priority is start, then stop, then a key press.
  always_comb begin
    state_d = state_q;
    ones_d  = ones_q;
    tens_d  = tens_q;
    mins_d  = mins_q;
    first_d = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if ({mins_q, tens_q, ones_q} == 12'h000) begin
            state_d = S_IDLE;
          end else if (tens_q > 4'd5) begin
            err_d = 1'b1;
          end else begin
            state_d = S_LOAD;
          end
        end else if (stop) begin
          ones_d = '0;
          tens_d = '0;
          mins_d = '0;
        end else if (key_valid && (key_digit <= 4'd9)) begin
          mins_d = tens_q;
          tens_d = ones_q;
          ones_d = key_digit;
        end
      end
      S_LOAD: begin
        state_d = S_RUN;
        first_d = 1'b1;
      end
      S_RUN: begin
        if (timer_zero && !first_q) begin
          state_d = S_DONE;
        end else if (stop) begin
          state_d = S_PAUSE;
        end
      end
      S_PAUSE: begin
        if (stop) begin
          ones_d  = '0;
          tens_d  = '0;
          mins_d  = '0;
          state_d = S_IDLE;
        end else if (start) begin
          state_d = S_RUN;
        end
      end
      S_DONE: begin
        ones_d  = '0;
        tens_d  = '0;
        mins_d  = '0;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs are pure state decodes or registers; no input reaches them
  // combinationally.
  always_comb begin
    loadn     = (state_q != S_LOAD);
    en        = (state_q == S_RUN);
    busy      = (state_q == S_LOAD) || (state_q == S_RUN) || (state_q == S_PAUSE);
    done      = (state_q == S_DONE);
    err       = err_q;
    data_ones = ones_q;
    data_tens = tens_q;
    data_mins = mins_q;
  end

endmodule

// File: tb/tb_timer_entry_loader.sv
// Scoreboard bench for timer_entry_loader: a stimulus process drives one
// cycle of inputs at each falling edge, advances a behavioural model and
// queues the expected outputs; a monitor compares them after each rising edge.
module tb_timer_entry_loader;

  logic       clk;
  logic       clear;
  logic       key_valid;
  logic [3:0] key_digit;
  logic       start;
  logic       stop;
  logic       timer_zero;
  logic       loadn;
  logic [3:0] data_ones;
  logic [3:0] data_tens;
  logic [3:0] data_mins;
  logic       en;
  logic       busy;
  logic       done;
  logic       err;

  timer_entry_loader dut (
    .clk        (clk),
    .clear      (clear),
    .key_valid  (key_valid),
    .key_digit  (key_digit),
    .start      (start),
    .stop       (stop),
    .timer_zero (timer_zero),
    .loadn      (loadn),
    .data_ones  (data_ones),
    .data_tens  (data_tens),
    .data_mins  (data_mins),
    .en         (en),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;

  // Expected output word: {loadn, mins, tens, ones, en, busy, done, err}
  logic [16:0] exp_q[$];

  // Behavioural model: the entry is held as a decimal number 0..999 and
  // the sequencer as a named phase.
  localparam int PH_IDLE  = 0;
  localparam int PH_LOAD  = 1;
  localparam int PH_RUN   = 2;
  localparam int PH_PAUSE = 3;
  localparam int PH_DONE  = 4;

  int m_phase = PH_IDLE;
  int m_entry = 0;
  int m_run_age = 0;
  bit m_err = 1'b0;

  function automatic logic [16:0] model_out();
    logic [3:0] mi, te, on;
    mi = 4'(m_entry / 100);
    te = 4'((m_entry / 10) % 10);
    on = 4'(m_entry % 10);
    return {m_phase != PH_LOAD, mi, te, on, m_phase == PH_RUN,
            (m_phase == PH_LOAD) || (m_phase == PH_RUN) || (m_phase == PH_PAUSE),
            m_phase == PH_DONE, m_err};
  endfunction

  function automatic void model_reset();
    m_phase = PH_IDLE;
    m_entry = 0;
    m_run_age = 0;
    m_err = 1'b0;
  endfunction

  function automatic void model_step(bit kv, int kd, bit s, bit p, bit tz);
    m_err = 1'b0;
    case (m_phase)
      PH_IDLE: begin
        if (s) begin
          if (m_entry == 0) begin
            m_phase = PH_IDLE;
          end else if ((m_entry / 10) % 10 > 5) begin
            m_err = 1'b1;
          end else begin
            m_phase = PH_LOAD;
          end
        end else if (p) begin
          m_entry = 0;
        end else if (kv && kd <= 9) begin
          m_entry = (m_entry * 10 + kd) % 1000;
        end
      end
      PH_LOAD: begin
        m_phase = PH_RUN;
        m_run_age = 0;
      end
      PH_RUN: begin
        if (tz && m_run_age > 0) m_phase = PH_DONE;
        else if (p) m_phase = PH_PAUSE;
        m_run_age = m_run_age + 1;
      end
      PH_PAUSE: begin
        if (p) begin
          m_entry = 0;
          m_phase = PH_IDLE;
        end else if (s) begin
          m_phase = PH_RUN;
          m_run_age = 1;
        end
      end
      default: begin
        m_entry = 0;
        m_phase = PH_IDLE;
      end
    endcase
  endfunction

  // One clock cycle of stimulus.
  task automatic step(input bit kv, input int kd, input bit s, input bit p, input bit tz);
    @(negedge clk);
    key_valid  = kv;
    key_digit  = 4'(kd);
    start      = s;
    stop       = p;
    timer_zero = tz;
    model_step(kv, kd, s, p, tz);
    exp_q.push_back(model_out());
  endtask

  task automatic key(input int d);
    step(1'b1, d, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 0, 1'b0, 1'b0, 1'b0);
  endtask

  // Assert clear between edges and check the outputs drop before the next edge.
  task automatic async_clear();
    @(negedge clk);
    key_valid  = 1'b0;
    start      = 1'b0;
    stop       = 1'b0;
    timer_zero = 1'b0;
    #2 clear = 1'b1;
    #1;
    n_cmp++;
    if (en !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || loadn !== 1'b1 ||
        {data_mins, data_tens, data_ones} !== 12'h000) begin
      n_mis++;
      $display("FAIL async_clear: en=%b busy=%b done=%b loadn=%b data=%h, required en=0 busy=0 done=0 loadn=1 data=000",
               en, busy, done, loadn, {data_mins, data_tens, data_ones});
    end
    model_reset();
    exp_q.push_back(model_out());
    @(negedge clk);
    clear = 1'b0;
    model_step(1'b0, 0, 1'b0, 1'b0, 1'b0);
    exp_q.push_back(model_out());
  endtask

  // Monitor: every rising edge presents a new output word.
  initial begin
    logic [16:0] act;
    logic [16:0] expv;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        expv = exp_q.pop_front();
        act  = {loadn, data_mins, data_tens, data_ones, en, busy, done, err};
        n_cmp++;
        if (act !== expv) begin
          n_mis++;
          $display("FAIL cycle_outputs @%0t: got loadn=%b mmss=%h en=%b busy=%b done=%b err=%b, required loadn=%b mmss=%h en=%b busy=%b done=%b err=%b",
                   $time, act[16], act[15:4], act[3], act[2], act[1], act[0],
                   expv[16], expv[15:4], expv[3], expv[2], expv[1], expv[0]);
        end
      end
    end
  end

  initial begin
    clear      = 1'b1;
    key_valid  = 1'b0;
    key_digit  = '0;
    start      = 1'b0;
    stop       = 1'b0;
    timer_zero = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({loadn, data_mins, data_tens, data_ones, en, busy, done, err} !== 17'h10000) begin
      n_mis++;
      $display("FAIL reset_state: got %h, required 10000",
               {loadn, data_mins, data_tens, data_ones, en, busy, done, err});
    end
    clear = 1'b0;

    // Key entry with shift-out and an invalid digit.
    key(1); key(3); key(0); key(7); key(10);
    step(1'b0, 0, 1'b0, 1'b1, 1'b0);

    // Load and run; timer_zero in the first RUN cycle must be ignored.
    key(5);
    step(1'b0, 0, 1'b1, 1'b0, 1'b0);
    idle(1);
    step(1'b0, 0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 0, 1'b0, 1'b0, 1'b1);
    idle(2);

    // Rejections: tens > 5, then all-zero entry.
    key(0); key(6); key(0);
    step(1'b0, 0, 1'b1, 1'b0, 1'b0);
    idle(1);
    step(1'b0, 0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 0, 1'b1, 1'b0, 1'b0);
    idle(1);

    // Pause, resume, cancel.
    key(1); key(2);
    step(1'b0, 0, 1'b1, 1'b0, 1'b0);
    idle(2);
    step(1'b0, 0, 1'b0, 1'b1, 1'b0);
    idle(1);
    step(1'b0, 0, 1'b1, 1'b0, 1'b0);
    idle(1);
    step(1'b0, 0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 0, 1'b1, 1'b1, 1'b0);
    idle(1);

    // Collisions: key+start, then stop+timer_zero in RUN.
    key(1); key(2);
    step(1'b1, 4, 1'b1, 1'b0, 1'b0);
    idle(2);
    step(1'b0, 0, 1'b0, 1'b1, 1'b1);
    idle(2);

    // Asynchronous clear during RUN.
    key(9);
    step(1'b0, 0, 1'b1, 1'b0, 1'b0);
    idle(2);
    async_clear();
    idle(1);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        async_clear();
      end else begin
        step($urandom_range(0, 99) < 40, int'($urandom_range(0, 15)),
             $urandom_range(0, 99) < 15, $urandom_range(0, 99) < 6,
             $urandom_range(0, 99) < 8);
      end
    end

    idle(1);
    repeat (3) @(negedge clk);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_mis++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/timer_entry_loader.md
TIMER_ENTRY_LOADER -- requirements
Module: timer_entry_loader

Interface
REQ-001 SHALL have these ports:
- clk  input  1  system clock; all state updates on rising edge
- clear  input  1  asynchronous, active-high reset
- key_valid  input  1  one-cycle strobe; key_digit is valid
- key_digit  input  4  BCD digit from keypad
- start  input  1  one-cycle start/resume command
- stop  input  1  one-cycle pause/cancel command
- timer_zero  input  1  high when the downstream mod-10 counter chain reads all zeros
- loadn  output  1  active-low parallel-load strobe to the counter chain
- data_ones  output  4  seconds-units digit for the counter load
- data_tens  output  4  seconds-tens digit for the counter load
- data_mins  output  4  minutes digit for the counter load
- en  output  1  count enable to the counter chain
- busy  output  1  high in LOAD, RUN or PAUSE
- done  output  1  one-cycle pulse when a countdown completes
- err  output  1  one-cycle pulse when start is rejected

Function
REQ-002 SHALL implement the FSM states IDLE, LOAD, RUN, PAUSE and DONE.
REQ-003 IDLE: on key_valid with key_digit <= 9, SHALL shift the entry left in the same edge: data_mins <= data_tens, data_tens <= data_ones, data_ones <= key_digit.
REQ-004 In IDLE, a fourth and later digit SHALL discard the oldest digit (shift-out); there is no overflow flag.
REQ-005 key_valid with key_digit > 9 SHALL be ignored: no shift and no err.
REQ-006 key_valid outside IDLE SHALL be ignored.
REQ-007 IDLE, start with all three digits zero: SHALL be ignored; stay in IDLE, no err.
REQ-008 IDLE, start with data_tens > 5: SHALL pulse err high for one cycle, stay in IDLE, and keep the digits.
REQ-009 IDLE, otherwise on start: SHALL go to LOAD.
REQ-010 IDLE, key_valid and start in the same cycle: start SHALL take priority and the digit SHALL be dropped.
REQ-011 IDLE, stop: SHALL clear all three digits to 0.
REQ-012 LOAD SHALL last exactly one cycle with loadn = 0 and en = 0; data_* SHALL be held stable; next state RUN.
REQ-013 loadn SHALL be 1 in every state other than LOAD.
REQ-014 RUN: en SHALL be 1. timer_zero = 1 SHALL go to DONE; stop SHALL go to PAUSE.
REQ-015 RUN, timer_zero and stop in the same cycle: timer_zero SHALL take priority (go to DONE).
REQ-016 timer_zero SHALL be ignored in the first RUN cycle after LOAD, so the counter has one cycle to settle.
REQ-017 PAUSE: en SHALL be 0. start SHALL go to RUN; stop SHALL clear the digits and go to IDLE; start and stop together SHALL act as stop.
REQ-018 DONE SHALL last one cycle with done = 1 and en = 0; it SHALL clear the digits to 0; next state IDLE.
REQ-019 busy SHALL equal (state is LOAD, RUN or PAUSE).
REQ-020 data_* SHALL not change in LOAD, RUN or PAUSE.
REQ-021 All outputs SHALL be registered or decoded from state only, with no combinational path from any input to any output.

Reset
REQ-022 When clear = 1, regardless of clk, the block SHALL immediately enter IDLE with data_* = 0, loadn = 1, en = 0, busy = 0, done = 0 and err = 0.
REQ-023 Asserting clear mid-operation (LOAD, RUN or PAUSE) SHALL abort the sequence with no done pulse.
REQ-024 On release of clear, the first rising edge SHALL evaluate IDLE behaviour.

Verification
REQ-025 Key entry: keys 1, 3, 0 -> data_mins = 1, data_tens = 3, data_ones = 0. Then key 7 -> 3, 0, 7. Then key 0xA -> no change.
REQ-026 Load/run: entry 0,0,5, then start -> exactly one cycle of loadn = 0 with data = 0,0,5 -> en = 1 next cycle. Hold timer_zero = 1 from the second RUN cycle -> one done pulse, then data = 0,0,0 and busy = 0.
REQ-027 Rejections: entry 0,6,0 + start -> err pulse, state IDLE, data unchanged. Entry 0,0,0 + start -> no err, no loadn.
REQ-028 Pause/resume/cancel: in RUN, stop -> en = 0. Then start -> en = 1. Then stop, stop -> data = 0, busy = 0, no done.
REQ-029 Collisions: key_valid(4) + start on an entry of 0,1,2 -> LOAD with 0,1,2. In RUN, stop + timer_zero together -> done pulse.
REQ-030 Async reset: assert clear between clock edges during RUN -> en = 0 and busy = 0 before the next edge, with no done pulse.
